// File: rtl/jamma_joy_scanner_if.sv
// ============================================================================
// Module   : jamma_joy_scanner_if
// Purpose  : JAMMA joystick bus bundle between the edge connector side and the
//            scanner (raw switches in, debounced levels and mux select out).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface jamma_joy_scanner_if;
    logic [7:0] jjoy;
    logic [5:0] zx_joy;
    logic [1:0] jcoin;
    logic       jselect;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic [1:0] coin;
    logic       scan_done;

    modport master (
        output jjoy, zx_joy, jcoin,
        input  jselect, joy1, joy2, coin, scan_done
    );

    modport slave (
        input  jjoy, zx_joy, jcoin,
        output jselect, joy1, joy2, coin, scan_done
    );
endinterface

`default_nettype wire

// File: rtl/jamma_joy_scanner.sv
// ============================================================================
// Module   : jamma_joy_scanner
// Purpose  : Time-multiplexed JAMMA P1/P2 joystick scanner with per-bit
//            debounce, coin debounce and on-board joystick merge.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module jamma_joy_scanner #(
    parameter int SETTLE     = 4,
    parameter int DB_SAMPLES = 3
) (
    input  wire logic            clk12,
    input  wire logic            RESET_L,
    jamma_joy_scanner_if.slave   io
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        SETTLE_P1 = 2'd0,
        SAMPLE_P1 = 2'd1,
        SETTLE_P2 = 2'd2,
        SAMPLE_P2 = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               settle_cnt_q, settle_cnt_d;
    logic                           jselect_q;
    logic                           scan_done_q;

    logic [7:0]                     jjoy_meta_q, jjoy_sync_q;
    logic [5:0]                     zx_meta_q, zx_sync_q;
    logic [1:0]                     coin_meta_q, coin_sync_q;

    // Histories are stored per bit so each bit's samples form one vector.
    logic [7:0][DB_SAMPLES-1:0]     p1_hist_q, p1_hist_d;
    logic [7:0][DB_SAMPLES-1:0]     p2_hist_q, p2_hist_d;
    logic [1:0][DB_SAMPLES-1:0]     coin_hist_q, coin_hist_d;
    logic [7:0]                     p1_db_q, p1_db_d;
    logic [7:0]                     p2_db_q, p2_db_d;
    logic [1:0]                     coin_db_q, coin_db_d;
    logic [7:0]                     joy1_q;

    always_ff @(posedge clk12 or negedge RESET_L) begin
        if (!RESET_L) begin
            jjoy_meta_q <= '1;
            jjoy_sync_q <= '1;
            zx_meta_q   <= '1;
            zx_sync_q   <= '1;
            coin_meta_q <= '1;
            coin_sync_q <= '1;
        end else begin
            jjoy_meta_q <= io.jjoy;
            jjoy_sync_q <= jjoy_meta_q;
            zx_meta_q   <= io.zx_joy;
            zx_sync_q   <= zx_meta_q;
            coin_meta_q <= io.jcoin;
            coin_sync_q <= coin_meta_q;
        end
    end

    // Settle counter is zero on entry to every settle state.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = '0;
        case (state_q)
            SETTLE_P1: begin
                if (settle_cnt_q == CNT_W'(SETTLE - 1)) state_d = SAMPLE_P1;
                else settle_cnt_d = settle_cnt_q + 1'b1;
            end
            SAMPLE_P1: state_d = SETTLE_P2;
            SETTLE_P2: begin
                if (settle_cnt_q == CNT_W'(SETTLE - 1)) state_d = SAMPLE_P2;
                else settle_cnt_d = settle_cnt_q + 1'b1;
            end
            SAMPLE_P2: state_d = SETTLE_P1;
            default:   state_d = SETTLE_P1;
        endcase
    end

    // A bit flips only when its whole history (including the sample being
    // taken now) agrees, so the new level appears right after the sample state.
    always_comb begin
        p1_hist_d   = p1_hist_q;
        p2_hist_d   = p2_hist_q;
        coin_hist_d = coin_hist_q;
        p1_db_d     = p1_db_q;
        p2_db_d     = p2_db_q;
        coin_db_d   = coin_db_q;
        for (int b = 0; b < 8; b++) begin
            if (state_q == SAMPLE_P1)
                p1_hist_d[b] = {p1_hist_q[b][DB_SAMPLES-2:0], jjoy_sync_q[b]};
            if (state_q == SAMPLE_P2)
                p2_hist_d[b] = {p2_hist_q[b][DB_SAMPLES-2:0], jjoy_sync_q[b]};
            if (&p1_hist_d[b])       p1_db_d[b] = 1'b1;
            else if (~|p1_hist_d[b]) p1_db_d[b] = 1'b0;
            if (&p2_hist_d[b])       p2_db_d[b] = 1'b1;
            else if (~|p2_hist_d[b]) p2_db_d[b] = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            if ((state_q == SAMPLE_P1) || (state_q == SAMPLE_P2))
                coin_hist_d[c] = {coin_hist_q[c][DB_SAMPLES-2:0], coin_sync_q[c]};
            if (&coin_hist_d[c])       coin_db_d[c] = 1'b1;
            else if (~|coin_hist_d[c]) coin_db_d[c] = 1'b0;
        end
    end

    always_ff @(posedge clk12 or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q      <= SETTLE_P1;
            settle_cnt_q <= '0;
            jselect_q    <= 1'b0;
            scan_done_q  <= 1'b0;
            p1_hist_q    <= '1;
            p2_hist_q    <= '1;
            coin_hist_q  <= '1;
            p1_db_q      <= '1;
            p2_db_q      <= '1;
            coin_db_q    <= '1;
            joy1_q       <= '1;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            jselect_q    <= (state_d == SETTLE_P2) || (state_d == SAMPLE_P2);
            scan_done_q  <= (state_q == SAMPLE_P2);
            p1_hist_q    <= p1_hist_d;
            p2_hist_q    <= p2_hist_d;
            coin_hist_q  <= coin_hist_d;
            p1_db_q      <= p1_db_d;
            p2_db_q      <= p2_db_d;
            coin_db_q    <= coin_db_d;
            joy1_q       <= p1_db_d & {2'b11, zx_sync_q};
        end
    end

    assign io.jselect   = jselect_q;
    assign io.scan_done = scan_done_q;
    assign io.joy1      = joy1_q;
    assign io.joy2      = p2_db_q;
    assign io.coin      = coin_db_q;

endmodule

`default_nettype wire
